// File: rtl/mag_scan_ctrl_pkg.sv
// Shared types and constants for the FFT magnitude scan controller.
package mag_scan_ctrl_pkg;

  localparam int ADDR_W = 10;
  localparam int MAG_W  = 16;
  localparam int FFT_N  = 1024;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/mag_scan_ctrl_if.sv
// Magnitude-RAM read port plus the aligned sample stream toward the peak detector.
// master: the scan controller. slave: the RAM and downstream peak detector.
interface mag_scan_ctrl_if;

  logic                               ram_rd_en;
  logic [mag_scan_ctrl_pkg::ADDR_W-1:0] ram_rd_addr;
  logic [mag_scan_ctrl_pkg::MAG_W-1:0]  ram_rd_data;
  logic [mag_scan_ctrl_pkg::MAG_W-1:0]  mag_data;
  logic [mag_scan_ctrl_pkg::ADDR_W-1:0] mag_addr;
  logic                               mag_valid;
  logic                               scan_en;
  logic                               scan_done;

  modport master (
    output ram_rd_en, ram_rd_addr, mag_data, mag_addr, mag_valid, scan_en, scan_done,
    input  ram_rd_data
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr, mag_data, mag_addr, mag_valid, scan_en, scan_done,
    output ram_rd_data
  );

endinterface

// File: rtl/scan_delay_line.sv
// Delays the read strobe and address by the RAM read latency so they line up
// with the returned data. pre_valid is the strobe about to enter the last
// stage, used to capture the RAM data in step with the output valid.
module scan_delay_line
  import mag_scan_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              pre_valid
);

  logic [DEPTH-1:0]  vld_pipe;
  logic [ADDR_W-1:0] addr_pipe [DEPTH];

  // Shift register for strobe and address; an abort empties it in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < DEPTH; i++) addr_pipe[i] <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
      for (int i = 0; i < DEPTH; i++) addr_pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= in_valid;
      addr_pipe[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[DEPTH-1];
  assign out_addr  = addr_pipe[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_tap_in
      assign pre_valid = in_valid;
    end else begin : g_tap_pipe
      assign pre_valid = vld_pipe[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/mag_scan_ctrl.sv
// Scan controller: on a rising edge of start, reads SCAN_LEN-FIRST_ADDR bins
// from the magnitude RAM and streams them, latency-aligned, to the peak
// detector. key aborts any pass.
// Optional build macro MAG_SCAN_SKIP_DC_EN: start the scan at bin 1 (skip DC).
module mag_scan_ctrl
  import mag_scan_ctrl_pkg::*;
#(
  parameter int SCAN_LEN = 512,
  parameter int RD_LAT   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            key,
  output logic            busy,
  mag_scan_ctrl_if.master bus
);

`ifdef MAG_SCAN_SKIP_DC_EN
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(0);
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SCAN_LEN - 1);
  localparam logic [2:0]        DRAIN_INIT = 3'(RD_LAT - 1);

  scan_state_t       state;
  logic              start_q;
  logic              start_edge;
  logic [2:0]        drain_cnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              scan_en;
  logic              scan_done;
  logic [MAG_W-1:0]  mag_data;
  logic              dl_valid;
  logic [ADDR_W-1:0] dl_addr;
  logic              dl_pre_valid;

  assign start_edge = start & ~start_q;

  // Pass sequencer with all control outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      drain_cnt <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      scan_en   <= 1'b0;
      scan_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      start_q <= start;
      if (key) begin
        state     <= IDLE;
        drain_cnt <= '0;
        rd_en     <= 1'b0;
        rd_addr   <= '0;
        scan_en   <= 1'b0;
        scan_done <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            scan_done <= 1'b0;
            if (start_edge) begin
              state   <= SCAN;
              rd_en   <= 1'b1;
              rd_addr <= FIRST_ADDR;
              scan_en <= 1'b1;
              busy    <= 1'b1;
            end
          end
          SCAN: begin
            if (rd_addr == LAST_ADDR) begin
              state     <= DRAIN;
              rd_en     <= 1'b0;
              rd_addr   <= '0;
              drain_cnt <= DRAIN_INIT;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
          DRAIN: begin
            if (drain_cnt == 3'd0) begin
              state     <= DONE;
              scan_done <= 1'b1;
              scan_en   <= 1'b0;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
          DONE: begin
            state     <= IDLE;
            scan_done <= 1'b0;
            busy      <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  scan_delay_line #(.DEPTH(RD_LAT)) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (key),
    .in_valid  (rd_en),
    .in_addr   (rd_addr),
    .out_valid (dl_valid),
    .out_addr  (dl_addr),
    .pre_valid (dl_pre_valid)
  );

  // Capture RAM data on the same edge that raises mag_valid for that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_data <= '0;
    end else if (!key && dl_pre_valid) begin
      mag_data <= bus.ram_rd_data;
    end
  end

  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = rd_addr;
  assign bus.mag_data    = mag_data;
  assign bus.mag_addr    = dl_addr;
  assign bus.mag_valid   = dl_valid;
  assign bus.scan_en     = scan_en;
  assign bus.scan_done   = scan_done;

endmodule

// File: tb/tb_mag_scan_ctrl.sv
// Bench for mag_scan_ctrl: randomized start/key traffic against a timeline
// model of each pass, with a queue-based scoreboard checked by a monitor.
module tb_mag_scan_ctrl;
  import mag_scan_ctrl_pkg::*;

  localparam int SCAN_LEN = 512;
  localparam int LAT      = 3;
`ifdef MAG_SCAN_SKIP_DC_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NSAMP = SCAN_LEN - FIRST;

  typedef struct {
    int edge_n;
    int addr;
    int data;
  } sample_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic key   = 1'b0;
  logic busy;

  mag_scan_ctrl_if bus_if ();

  mag_scan_ctrl #(.SCAN_LEN(SCAN_LEN), .RD_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .key   (key),
    .busy  (busy),
    .bus   (bus_if)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Edge index: value seen after edge n is n.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // RAM contents and a read path with LAT cycles from strobe to capture.
  logic [MAG_W-1:0]  mem [FFT_N];
  logic [ADDR_W-1:0] rp  [LAT-1];

  initial begin
    for (int i = 0; i < FFT_N; i++) mem[i] = MAG_W'($urandom);
  end

  always @(posedge clk) begin
    rp[0] <= bus_if.ram_rd_addr;
    for (int i = 1; i < LAT - 1; i++) rp[i] <= rp[i-1];
  end

  assign bus_if.ram_rd_data = mem[rp[LAT-2]];

  // Pass timeline model: intervals (in edge indices) during which each output is high.
  int  p_start   = -1;
  int  rd_end    = -1;
  int  scan_end  = -1;
  int  busy_end  = -1;
  int  idle_from = 0;
  bit  prev_start = 1'b0;
  bit  mon_en = 1'b0;
  sample_t exp_q[$];
  int      done_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit k);
    int e;
    @(negedge clk);
    start = s;
    key   = k;
    e = edge_cnt + 1;
    if (k) begin
      while (exp_q.size() > 0 && exp_q[$].edge_n >= e) void'(exp_q.pop_back());
      while (done_q.size() > 0 && done_q[$] >= e) void'(done_q.pop_back());
      if (rd_end > e) rd_end = e;
      if (scan_end > e) scan_end = e;
      if (busy_end > e) busy_end = e;
      if (idle_from > e) idle_from = e + 1;
    end else if (s && !prev_start && e >= idle_from) begin
      p_start   = e;
      rd_end    = e + NSAMP;
      scan_end  = e + NSAMP + LAT;
      busy_end  = e + NSAMP + LAT + 1;
      idle_from = e + NSAMP + LAT + 2;
      for (int j = 0; j < NSAMP; j++)
        exp_q.push_back('{edge_n: e + j + LAT, addr: FIRST + j, data: int'(mem[FIRST + j])});
      done_q.push_back(e + NSAMP + LAT);
    end
    prev_start = s;
  endtask

  task automatic resetModel();
    exp_q.delete();
    done_q.delete();
    p_start    = -1;
    rd_end     = -1;
    scan_end   = -1;
    busy_end   = -1;
    idle_from  = 0;
    prev_start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ram_rd_en"},   bus_if.ram_rd_en,   0);
    checkOutput({tag, "_ram_rd_addr"}, bus_if.ram_rd_addr, 0);
    checkOutput({tag, "_mag_valid"},   bus_if.mag_valid,   0);
    checkOutput({tag, "_mag_addr"},    bus_if.mag_addr,    0);
    checkOutput({tag, "_mag_data"},    bus_if.mag_data,    0);
    checkOutput({tag, "_scan_en"},     bus_if.scan_en,     0);
    checkOutput({tag, "_scan_done"},   bus_if.scan_done,   0);
    checkOutput({tag, "_busy"},        busy,               0);
  endtask

  // Monitor: compares controls every cycle and pops scoreboard entries when due.
  int      mn;
  bit      rd_exp;
  sample_t ms;
  int      md;

  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n) begin
      mn = edge_cnt;
      rd_exp = (mn >= p_start) && (mn < rd_end);
      checkOutput("ram_rd_en", bus_if.ram_rd_en, rd_exp);
      checkOutput("ram_rd_addr", bus_if.ram_rd_addr, rd_exp ? (FIRST + mn - p_start) : 0);
      checkOutput("scan_en", bus_if.scan_en, (mn >= p_start) && (mn < scan_end));
      checkOutput("busy", busy, (mn >= p_start) && (mn < busy_end));
      if (exp_q.size() > 0 && exp_q[0].edge_n == mn) begin
        ms = exp_q.pop_front();
        checkOutput("mag_valid", bus_if.mag_valid, 1);
        if (bus_if.mag_valid) begin
          checkOutput("mag_addr", bus_if.mag_addr, ms.addr);
          checkOutput("mag_data", bus_if.mag_data, ms.data);
        end
      end else begin
        checkOutput("mag_valid", bus_if.mag_valid, 0);
      end
      if (done_q.size() > 0 && done_q[0] == mn) begin
        md = done_q.pop_front();
        checkOutput("scan_done", bus_if.scan_done, 1);
      end else begin
        checkOutput("scan_done", bus_if.scan_done, 0);
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  bit cur_s;

  initial begin
    $display("[TB] start, FIRST=%0d NSAMP=%0d LAT=%0d", FIRST, NSAMP, LAT);
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) applyStimulus(0, 0);

    // Basic pass from a one-cycle start pulse.
    applyStimulus(1, 0);
    repeat (NSAMP + LAT + 6) applyStimulus(0, 0);

    // Start held high with a second edge mid-pass: one pass only.
    applyStimulus(1, 0);
    repeat (98) applyStimulus(1, 0);
    applyStimulus(0, 0);
    repeat (900) applyStimulus(1, 0);
    repeat (5) applyStimulus(0, 0);

    // Abort at address FIRST+200, then a fresh full pass.
    applyStimulus(1, 0);
    repeat (200) applyStimulus(0, 0);
    applyStimulus(0, 1);
    repeat (5) applyStimulus(0, 0);
    applyStimulus(1, 0);
    repeat (NSAMP + LAT + 6) applyStimulus(0, 0);

    // key and start edge together: no pass.
    applyStimulus(1, 1);
    repeat (10) applyStimulus(0, 0);

    // Random start toggling with occasional aborts.
    cur_s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) cur_s = ~cur_s;
      applyStimulus(cur_s, $urandom_range(0, 499) == 0);
    end
    repeat (NSAMP + LAT + 6) applyStimulus(0, 0);

    // Reset asserted while draining.
    applyStimulus(1, 0);
    repeat (NSAMP + 1) applyStimulus(0, 0);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_drain");
    resetModel();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (5) applyStimulus(0, 0);
    applyStimulus(1, 0);
    repeat (NSAMP + LAT + 6) applyStimulus(0, 0);

    checkOutput("pending_samples", exp_q.size(), 0);
    checkOutput("pending_done", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
